// File: rtl/shift_sequencer.sv
// Shift/rotate sequencer: loads a word, then shifts it once per prescaler tick
// for a counted number of steps or until stopped.
module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   input  logic [3:0]       count,
   input  logic [4:0]       div_sel,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] data_out,
   output logic             busy,
   output logic             done,
   output logic             tick
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] data_q;
   logic [1:0]       mode_q;
   logic [4:0]       div_q;
   logic [DIV_W-1:0] presc_q;
   logic [3:0]       rem_q;
   logic             free_q;
   logic             busy_q;
   logic             done_q;
   logic             tick_q;

   logic [4:0]       div_cap;
   logic [DIV_W-1:0] term;
   logic [DIV_W-1:0] presc_d;
   logic             at_term;

   function automatic logic [WIDTH-1:0] shift_by_mode(input logic [1:0] m,
                                                      input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      case (m)
         2'b00:   r = {v[WIDTH-2:0], 1'b0};
         2'b01:   r = {1'b0, v[WIDTH-1:1]};
         2'b10:   r = {v[WIDTH-2:0], v[WIDTH-1]};
         default: r = {v[0], v[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   // Terminal count 2^d-1; in a narrow prescaler build large d saturates to all ones.
   always_comb begin
      div_cap = (div_sel > 5'd24) ? 5'd24 : div_sel;
      term    = (DIV_W'(1) << div_q) - DIV_W'(1);
      at_term = (presc_q == term);
      presc_d = at_term ? '0 : (presc_q + DIV_W'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         mode_q  <= 2'b00;
         div_q   <= 5'd0;
         presc_q <= '0;
         rem_q   <= 4'd0;
         free_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               tick_q <= 1'b0;
               if (start) begin
                  data_q  <= load_data;
                  mode_q  <= mode;
                  div_q   <= div_cap;
                  presc_q <= '0;
                  rem_q   <= count;
                  free_q  <= (count == 4'd0);
                  busy_q  <= 1'b1;
                  tick_q  <= (div_cap == 5'd0);
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (stop) begin
                  presc_q <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  tick_q  <= 1'b0;
                  state_q <= S_DONE;
               end else if (at_term && !free_q && rem_q == 4'd1) begin
                  data_q  <= shift_by_mode(mode_q, data_q);
                  rem_q   <= 4'd0;
                  presc_q <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  tick_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  if (at_term) begin
                     data_q <= shift_by_mode(mode_q, data_q);
                     if (!free_q) rem_q <= rem_q - 4'd1;
                  end
                  presc_q <= presc_d;
                  tick_q  <= (presc_d == term);
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               tick_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               tick_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign data_out = data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign tick     = tick_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: per-cycle expected {busy,done,tick,data_out}
// words are queued for each operation and compared on the falling edge.
module tb_shift_sequencer;
   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         start2;
   logic         stop;
   logic [1:0]   mode;
   logic [3:0]   count;
   logic [4:0]   div_sel;
   logic [W-1:0] load_data;
   logic [W-1:0] data_out;
   logic [W-1:0] data_out2;
   logic         busy, done, tick;
   logic         busy2, done2, tick2;

   logic [W+2:0] exp_q[$];
   int           checks;
   int           errors;

   shift_sequencer #(.WIDTH(W), .DIV_W(25)) u_dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .count(count), .div_sel(div_sel), .load_data(load_data),
      .data_out(data_out), .busy(busy), .done(done), .tick(tick)
   );

   // Narrow prescaler build so the clamped terminal count is reachable quickly.
   shift_sequencer #(.WIDTH(W), .DIV_W(6)) u_dut_narrow (
      .clk(clk), .rst(rst), .start(start2), .stop(stop), .mode(mode),
      .count(count), .div_sel(div_sel), .load_data(load_data),
      .data_out(data_out2), .busy(busy2), .done(done2), .tick(tick2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input logic [W-1:0] v);
      case (m)
         2'b00:   return v << 1;
         2'b01:   return v >> 1;
         2'b10:   return (v << 1) | (v >> (W-1));
         default: return (v >> 1) | (v << (W-1));
      endcase
   endfunction

   task automatic push_model(input logic [1:0] m, input logic [3:0] c, input int d,
                             input logic [W-1:0] ld, input int stop_cyc);
      logic [W-1:0] v = ld;
      int rem = int'(c);
      int p = 1 << d;
      int k = 0;
      bit fin = 1'b0;
      logic t;
      while (!fin && k < 5000) begin
         t = ((k % p) == p - 1);
         exp_q.push_back({1'b1, 1'b0, t, v});
         if (k == stop_cyc) fin = 1'b1;
         else if (t) begin
            v = ref_shift(m, v);
            if (c != 4'd0) begin
               rem--;
               if (rem == 0) fin = 1'b1;
            end
         end
         k++;
      end
      exp_q.push_back({1'b0, 1'b1, 1'b0, v});
      exp_q.push_back({1'b0, 1'b0, 1'b0, v});
   endtask

   // Starts one operation, then scrambles inputs and start while it runs.
   task automatic run_op(input logic [1:0] m, input logic [3:0] c, input logic [4:0] d,
                         input logic [W-1:0] ld, input int stop_cyc);
      int i = 0;
      logic [W+2:0] e;
      @(negedge clk);
      mode = m; count = c; div_sel = d; load_data = ld; start = 1'b1; stop = 1'b0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check_val("trace", {21'd0, busy, done, tick, data_out}, {21'd0, e});
         start     = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         mode      = 2'($urandom_range(0, 3));
         count     = 4'($urandom_range(0, 15));
         div_sel   = 5'($urandom_range(0, 31));
         load_data = 8'($urandom_range(0, 255));
         stop      = (i == stop_cyc);
         i++;
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic [1:0] rm;
      logic [3:0] rc;
      int rd;
      logic [W-1:0] rl;
      int rs;
      checks = 0; errors = 0;
      rst = 1'b1; start = 1'b0; start2 = 1'b0; stop = 1'b0;
      mode = 2'b00; count = 4'd0; div_sel = 5'd0; load_data = '0;
      repeat (2) @(negedge clk);
      check_val("reset_outputs", {busy, done, tick, data_out}, 32'd0);
      check_val("reset_outputs_narrow", {busy2, done2, tick2, data_out2}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("idle_after_reset", {busy, done, tick, data_out}, 32'd0);

      // Counted left shift, d=0
      exp_q.push_back({3'b101, 8'h01});
      exp_q.push_back({3'b101, 8'h02});
      exp_q.push_back({3'b101, 8'h04});
      exp_q.push_back({3'b010, 8'h08});
      exp_q.push_back({3'b000, 8'h08});
      run_op(2'b00, 4'd3, 5'd0, 8'h01, -1);

      // Rotate right, d=2, count 2
      repeat (3) exp_q.push_back({3'b100, 8'h81});
      exp_q.push_back({3'b101, 8'h81});
      repeat (3) exp_q.push_back({3'b100, 8'hC0});
      exp_q.push_back({3'b101, 8'hC0});
      exp_q.push_back({3'b010, 8'h60});
      exp_q.push_back({3'b000, 8'h60});
      run_op(2'b11, 4'd2, 5'd2, 8'h81, -1);

      // Free-run rotate left, stop coincident with 4th tick
      exp_q.push_back({3'b100, 8'h80}); exp_q.push_back({3'b101, 8'h80});
      exp_q.push_back({3'b100, 8'h01}); exp_q.push_back({3'b101, 8'h01});
      exp_q.push_back({3'b100, 8'h02}); exp_q.push_back({3'b101, 8'h02});
      exp_q.push_back({3'b100, 8'h04}); exp_q.push_back({3'b101, 8'h04});
      exp_q.push_back({3'b010, 8'h04});
      exp_q.push_back({3'b000, 8'h04});
      run_op(2'b10, 4'd0, 5'd1, 8'h80, 7);

      // Asynchronous reset in the middle of a run
      @(negedge clk);
      mode = 2'b00; count = 4'd5; div_sel = 5'd1; load_data = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("midrun_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 check_val("async_reset_outputs", {busy, done, tick, data_out}, 32'd0);
      @(negedge clk);
      check_val("no_done_in_reset", {busy, done, tick, data_out}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("idle_after_midrun_reset", {busy, done, tick, data_out}, 32'd0);
      push_model(2'b01, 4'd4, 1, 8'hA5, -1);
      run_op(2'b01, 4'd4, 5'd1, 8'hA5, -1);

      // Random operations against the reference model
      for (int j = 0; j < 10; j++) begin
         rm = 2'($urandom_range(0, 3));
         rc = 4'($urandom_range(0, 15));
         rd = $urandom_range(0, 3);
         rl = 8'($urandom_range(0, 255));
         if (rc == 4'd0) rs = $urandom_range(0, 20);
         else if ($urandom_range(0, 1) == 1) rs = $urandom_range(0, int'(rc) * (1 << rd) + 1);
         else rs = -1;
         push_model(rm, rc, rd, rl, rs);
         run_op(rm, rc, 5'(rd), rl, rs);
      end

      // Clamped div_sel on the narrow-prescaler build: first tick at prescaler 63
      @(negedge clk);
      mode = 2'b00; count = 4'd1; div_sel = 5'd31; load_data = 8'h01; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (!tick2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val("clamp_first_tick_cycle", 32'(n), 32'd63);
      check_val("clamp_busy_at_tick", {30'd0, busy2, data_out2 == 8'h01}, 32'd3);
      @(negedge clk);
      check_val("clamp_done", {busy2, done2, tick2, data_out2}, {21'd0, 3'b010, 8'h02});
      @(negedge clk);
      check_val("clamp_idle", {busy2, done2, tick2, data_out2}, {21'd0, 3'b000, 8'h02});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
